// File: rtl/tbus_arb_pkg.sv
// rtl/tbus_arb_pkg.sv - shared types and helpers for the tri-state bus arbiter
//
// Purpose: arbiter FSM state encoding and the index-width helper used to size
//          owner/index signals. No ports.
package tbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   // Width of an index into n items; never less than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//
// Purpose: finds the first set request bit at or after a start index, wrapping
//          around the vector.
// Ports:
//   req    in  N    request vector
//   start  in  IW   index searched first
//   win    out N    one-hot winner (zero when nothing requests)
//   idx    out IW   winner index
//   valid  out 1    at least one request present
module rr_pick
   import tbus_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  win,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Walk offsets from farthest to nearest so the nearest requester to
   // 'start' is the last one written and therefore wins.
   always_comb begin
      int j;
      win   = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int off = N - 1; off >= 0; off--) begin
         j = int'(start) + off;
         if (j >= N) j = j - N;
         if (req[j]) begin
            win    = '0;
            win[j] = 1'b1;
            idx    = IW'(j);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tbus_arbiter.sv
// rtl/tbus_arbiter.sv - round-robin arbiter and sequencer for a shared tri-state bus
//
// Purpose: grants one requester at a time, bounds each burst to MAX_BURST
//          cycles and, when TBUS_TURNAROUND_EN is defined, inserts one dead
//          cycle between owners so TBUF drivers never overlap. With the macro
//          undefined the next owner is granted at the release edge itself.
// Ports:
//   CLK     in   1       clock, rising edge
//   RESETn  in   1       asynchronous active-low reset
//   REQ     in   N_REQ   level requests
//   GNT     out  N_REQ   registered one-hot grant / TBUF enables
//   BUSY    out  1       any grant active
//   OWNER   out  IW      current or most recent grantee
//   LAST    out  1       final permitted cycle of the burst
module tbus_arbiter
   import tbus_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                      CLK,
   input  logic                      RESETn,
   input  logic [N_REQ-1:0]          REQ,
   output logic [N_REQ-1:0]          GNT,
   output logic                      BUSY,
   output logic [idx_w(N_REQ)-1:0]   OWNER,
   output logic                      LAST
);

   localparam int IW = idx_w(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_t           state, state_n;
   logic [N_REQ-1:0] gnt_n;
   logic [IW-1:0]    owner_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [IW-1:0]    start;
   logic [N_REQ-1:0] win;
   logic [IW-1:0]    win_idx;
   logic             win_valid;
   logic             hold;

   // Search begins just past the last owner, so it only wins again when alone.
   assign start = (OWNER == IW'(N_REQ - 1)) ? '0 : OWNER + IW'(1);

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req   (REQ),
      .start (start),
      .win   (win),
      .idx   (win_idx),
      .valid (win_valid)
   );

   // Owner keeps the bus while still requesting and under the burst limit;
   // a drop coinciding with the limit is one release.
   assign hold = REQ[OWNER] && (cnt < CW'(MAX_BURST));

   always_comb begin
      state_n = state;
      gnt_n   = GNT;
      owner_n = OWNER;
      cnt_n   = cnt;
      case (state)
         IDLE, TURN: begin
            if (win_valid) begin
               state_n = GRANT;
               gnt_n   = win;
               owner_n = win_idx;
               cnt_n   = CW'(1);
            end else begin
               state_n = IDLE;
               gnt_n   = '0;
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (hold) begin
               cnt_n = cnt + CW'(1);
            end else begin
`ifdef TBUS_TURNAROUND_EN
               state_n = TURN;
               gnt_n   = '0;
               cnt_n   = '0;
`else
               if (win_valid) begin
                  gnt_n   = win;
                  owner_n = win_idx;
                  cnt_n   = CW'(1);
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  cnt_n   = '0;
               end
`endif
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
         GNT   <= '0;
         OWNER <= IW'(N_REQ - 1);
         cnt   <= '0;
      end else begin
         state <= state_n;
         GNT   <= gnt_n;
         OWNER <= owner_n;
         cnt   <= cnt_n;
      end
   end

   assign BUSY = |GNT;
   assign LAST = BUSY && (cnt == CW'(MAX_BURST));

endmodule

// File: tb/tb_tbus_arbiter.sv
// tb/tb_tbus_arbiter.sv - self-checking bench for tbus_arbiter
module tb_tbus_arbiter;

`ifdef TBUS_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif
   localparam int MB  = 8;
   localparam int GAP = TURN_EN ? 1 : 0;

   logic       CLK;
   logic       RESETn;
   logic [3:0] REQ;
   logic [3:0] GNT;
   logic       BUSY;
   logic [1:0] OWNER;
   logic       LAST;

   int vectors;
   int miscompares;
   int m_owner;
   int m_run;
   logic [3:0] rnd_req;
   logic [3:0] m_gnt;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      int         owner;
      bit         last;
   } vec_t;

   vec_t tbl[17];

   tbus_arbiter #(
      .N_REQ     (4),
      .MAX_BURST (MB)
   ) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .REQ    (REQ),
      .GNT    (GNT),
      .BUSY   (BUSY),
      .OWNER  (OWNER),
      .LAST   (LAST)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step(input logic [3:0] r);
      REQ = r;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string nm, input logic [3:0] eg, input int eo, input bit el);
      vectors++;
      if (GNT !== eg || BUSY !== (eg != 4'b0000) || OWNER !== 2'(eo) ||
          LAST !== el || !$onehot0(GNT)) begin
         miscompares++;
         $display("FAIL %s: got gnt=%b busy=%b owner=%0d last=%b, expected gnt=%b busy=%b owner=%0d last=%b",
                  nm, GNT, BUSY, OWNER, LAST, eg, (eg != 4'b0000), eo, el);
      end
   endtask

   // Reference: pick the first requester after the previous owner, wrapping.
   task automatic model_pick(input logic [3:0] r);
      bit found;
      int base;
      found = 1'b0;
      base  = m_owner;
      for (int k = 1; k <= 4; k++) begin
         if (!found && r[(base + k) % 4]) begin
            found   = 1'b1;
            m_owner = (base + k) % 4;
            m_run   = 1;
         end
      end
   endtask

   // m_run = granted cycles so far in the current burst (0 = bus not granted).
   task automatic model_edge(input logic [3:0] r);
      if (m_run > 0 && r[m_owner] && m_run < MB) begin
         m_run++;
      end else if (m_run > 0) begin
         m_run = 0;
         if (!TURN_EN) model_pick(r);
      end else begin
         model_pick(r);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RESETn      = 1'b0;
      REQ         = 4'b0000;

      tbl[0]  = '{4'b0000, 4'b0000, 3, 1'b0};
      tbl[1]  = '{4'b0100, 4'b0100, 2, 1'b0};
      tbl[2]  = '{4'b0100, 4'b0100, 2, 1'b0};
      tbl[3]  = '{4'b0100, 4'b0100, 2, 1'b0};
      tbl[4]  = '{4'b0100, 4'b0100, 2, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, 2, 1'b0};
      tbl[6]  = '{4'b0011, 4'b0001, 0, 1'b0};
      tbl[7]  = '{4'b0011, 4'b0001, 0, 1'b0};
      tbl[8]  = '{4'b0011, 4'b0001, 0, 1'b0};
      tbl[9]  = '{4'b0010, TURN_EN ? 4'b0000 : 4'b0010, TURN_EN ? 0 : 1, 1'b0};
      tbl[10] = '{4'b0010, 4'b0010, 1, 1'b0};
      tbl[11] = '{4'b0000, 4'b0000, 1, 1'b0};
      tbl[12] = '{4'b0000, 4'b0000, 1, 1'b0};
      tbl[13] = '{4'b1000, 4'b1000, 3, 1'b0};
      tbl[14] = '{4'b1011, 4'b1000, 3, 1'b0};
      tbl[15] = '{4'b0000, 4'b0000, 3, 1'b0};
      tbl[16] = '{4'b0000, 4'b0000, 3, 1'b0};

      // Reset held, then released between edges with no requests.
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("reset_hold", 4'b0000, 3, 1'b0);
      #3;
      RESETn = 1'b1;
      #1;
      check("reset_release", 4'b0000, 3, 1'b0);

      // Single requester, early drop with handoff, non-owner request noise.
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].req);
         check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].owner, tbl[i].last);
      end

      // Asynchronous reset in the middle of a burst.
      step(4'b0001);
      check("pre_reset_grant", 4'b0001, 0, 1'b0);
      step(4'b0001);
      check("pre_reset_grant2", 4'b0001, 0, 1'b0);
      #3;
      RESETn = 1'b0;
      #1;
      check("async_reset_clear", 4'b0000, 3, 1'b0);
      @(posedge CLK);
      #3;
      RESETn = 1'b1;
      step(4'b1000);
      check("post_reset_grant", 4'b1000, 3, 1'b0);
      step(4'b0000);
      check("post_reset_release", 4'b0000, 3, 1'b0);
      step(4'b0000);
      check("post_reset_idle", 4'b0000, 3, 1'b0);

      // Saturation: five full bursts in owner order 0,1,2,3,0.
      for (int t = 0; t < 5 * (MB + GAP); t++) begin
         int b;
         int pos;
         logic [3:0] eg;
         b   = t / (MB + GAP);
         pos = t % (MB + GAP);
         eg  = (pos < MB) ? 4'(1 << (b % 4)) : 4'b0000;
         step(4'b1111);
         check($sformatf("saturate[%0d]", t), eg, b % 4, pos == MB - 1);
      end

      // Randomized requests against the reference model, from a fresh reset.
      #3;
      RESETn  = 1'b0;
      REQ     = 4'b0000;
      m_owner = 3;
      m_run   = 0;
      rnd_req = 4'b0000;
      @(posedge CLK);
      #3;
      RESETn = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) rnd_req[b] = ~rnd_req[b];
         end
         if ($urandom_range(0, 31) == 0) rnd_req = 4'b0000;
         step(rnd_req);
         model_edge(rnd_req);
         m_gnt = (m_run > 0) ? 4'(1 << m_owner) : 4'b0000;
         check($sformatf("random[%0d]", n), m_gnt, m_owner, m_run == MB);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
